// File: rtl/vote_logger.sv
// -----------------------------------------------------------------------------
// vote_logger
//
// Upstream stage of the mode/LED controller. Samples the four candidate
// push-buttons, admits exactly one vote per press while the mode switch is in
// voting position, and keeps a saturating tally per candidate. In result
// display mode the tallies are frozen and presses are ignored.
//
// Parameters
//   CNT_W        width of each candidate tally
//   HOLD_CYCLES  consecutive all-released cycles required to re-arm after a press
//
// Ports
//   clk                        system clock, rising edge
//   rst                        asynchronous reset, active-low
//   mode                       0 = voting, 1 = result display (quasi-static)
//   candidate1..4_button_press debounced button levels, asynchronous to clk
//   valid_vote_casted          1-cycle pulse per accepted vote
//   invalid_vote               1-cycle pulse when more than one button was seen
//                              at arm time
//   vote_cand1..vote_cand4     per-candidate tallies (saturating)
//   overflow                   sticky; set by a vote for an already saturated
//                              candidate, cleared only by reset
//
// Timing: a button sampled high at edge k reaches the FSM through the two-flop
// synchroniser at edge k+1, so the tally update and the pulse are registered
// together at edge k+2.
// -----------------------------------------------------------------------------
module vote_logger #(
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             candidate1_button_press,
    input  logic             candidate2_button_press,
    input  logic             candidate3_button_press,
    input  logic             candidate4_button_press,
    output logic             valid_vote_casted,
    output logic             invalid_vote,
    output logic [CNT_W-1:0] vote_cand1,
    output logic [CNT_W-1:0] vote_cand2,
    output logic [CNT_W-1:0] vote_cand3,
    output logic [CNT_W-1:0] vote_cand4,
    output logic             overflow
);

    localparam int NUM_CAND = 4;

    // Width of the re-arm counter; kept at least one bit wide so a
    // HOLD_CYCLES of 1 still elaborates.
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [CNT_W-1:0] TALLY_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronisers
    // -------------------------------------------------------------------------
    logic [NUM_CAND-1:0] btn_raw;
    logic [NUM_CAND-1:0] sync1_reg;
    logic [NUM_CAND-1:0] sync2_reg;

    assign btn_raw = {candidate4_button_press,
                      candidate3_button_press,
                      candidate2_button_press,
                      candidate1_button_press};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Arming FSM
    // -------------------------------------------------------------------------
    state_t            state_reg;
    state_t            state_next;
    logic [HOLD_W-1:0] hold_reg;
    logic [HOLD_W-1:0] hold_next;

    logic btn_any;
    logic btn_onehot;
    logic accept_valid;
    logic accept_invalid;

    assign btn_any    = |sync2_reg;
    assign btn_onehot = ($countones(sync2_reg) == 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        hold_next      = hold_reg;
        accept_valid   = 1'b0;
        accept_invalid = 1'b0;

        case (state_reg)
            IDLE: begin
                hold_next = '0;
                // In display mode presses are ignored entirely; we do not
                // even enter LOCK, so switching back to voting with a button
                // already held down registers that press.
                if (!mode && btn_any) begin
                    if (btn_onehot) begin
                        accept_valid = 1'b1;
                    end else begin
                        accept_invalid = 1'b1;
                    end
                    state_next = LOCK;
                end
            end

            LOCK: begin
                // Mode is deliberately not consulted here: the lockout only
                // ends after HOLD_CYCLES consecutive all-released cycles.
                if (btn_any) begin
                    hold_next = '0;
                end else if (hold_reg == HOLD_LAST) begin
                    hold_next  = '0;
                    state_next = IDLE;
                end else begin
                    hold_next = hold_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                hold_next  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Per-candidate saturating tallies
    // -------------------------------------------------------------------------
    logic [NUM_CAND-1:0][CNT_W-1:0] tally_bus;
    logic [NUM_CAND-1:0]            sat_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CAND; gi++) begin : g_cand
            logic [CNT_W-1:0] tally_reg;
            logic             hit;

            // accept_valid implies sync2_reg is one-hot, so at most one
            // candidate sees a hit in any cycle.
            assign hit = accept_valid && sync2_reg[gi];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    tally_reg <= '0;
                end else if (hit && (tally_reg != TALLY_MAX)) begin
                    tally_reg <= tally_reg + 1'b1;
                end
            end

            assign tally_bus[gi] = tally_reg;
            assign sat_vec[gi]   = (tally_reg == TALLY_MAX);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Pulses and sticky overflow
    // -------------------------------------------------------------------------
    logic valid_reg;
    logic invalid_reg;
    logic overflow_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg    <= 1'b0;
            invalid_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            // Registered on the same edge as the tally update, so the pulse
            // and the new count become visible together.
            valid_reg   <= accept_valid;
            invalid_reg <= accept_invalid;
            // A vote for a saturated candidate is still a valid vote; it just
            // leaves the count alone and latches overflow.
            if (accept_valid && |(sync2_reg & sat_vec)) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign valid_vote_casted = valid_reg;
    assign invalid_vote      = invalid_reg;
    assign overflow          = overflow_reg;

    assign vote_cand1 = tally_bus[0];
    assign vote_cand2 = tally_bus[1];
    assign vote_cand3 = tally_bus[2];
    assign vote_cand4 = tally_bus[3];

endmodule

// File: tb/tb_vote_logger.sv
// -----------------------------------------------------------------------------
// tb_vote_logger
//
// Directed bench for vote_logger. A behavioural model tracks what the outputs
// must be (votes seen two edges after sampling, re-arm after HOLD_CYCLES quiet
// samples, saturating tallies) and a compare process checks every output on
// every falling edge while out of reset. Directed steps add literal checks on
// pulse timing, pulse counts, tallies and reset behaviour.
// -----------------------------------------------------------------------------
module tb_vote_logger;

    localparam int CNT_W = 8;
    localparam int HOLD  = 10;
    localparam int TMAX  = (1 << CNT_W) - 1;

    logic             clk  = 1'b0;
    logic             rst  = 1'b0;
    logic             mode = 1'b0;
    logic [3:0]       btn  = 4'b0000;
    logic             valid_vote_casted;
    logic             invalid_vote;
    logic [CNT_W-1:0] vote_cand1;
    logic [CNT_W-1:0] vote_cand2;
    logic [CNT_W-1:0] vote_cand3;
    logic [CNT_W-1:0] vote_cand4;
    logic             overflow;

    vote_logger #(
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .mode                    (mode),
        .candidate1_button_press (btn[0]),
        .candidate2_button_press (btn[1]),
        .candidate3_button_press (btn[2]),
        .candidate4_button_press (btn[3]),
        .valid_vote_casted       (valid_vote_casted),
        .invalid_vote            (invalid_vote),
        .vote_cand1              (vote_cand1),
        .vote_cand2              (vote_cand2),
        .vote_cand3              (vote_cand3),
        .vote_cand4              (vote_cand4),
        .overflow                (overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    int       m_tally[4];
    bit       m_valid;
    bit       m_invalid;
    bit       m_ovf;
    bit       m_armed;
    int       m_quiet;
    bit [3:0] m_pipe[$];

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_tally[i] = 0;
        m_valid   = 0;
        m_invalid = 0;
        m_ovf     = 0;
        m_armed   = 1;
        m_quiet   = 0;
        m_pipe.delete();
    endtask

    // Called once per rising edge with the inputs present at that edge.
    task automatic model_step(input bit [3:0] b, input bit md);
        bit [3:0] seen;
        seen = 4'b0000;
        // The decision at this edge is based on the buttons of two edges ago.
        if (m_pipe.size() == 2) seen = m_pipe.pop_front();
        m_pipe.push_back(b);
        m_valid   = 0;
        m_invalid = 0;
        if (m_armed) begin
            if (!md && seen != 0) begin
                m_armed = 0;
                m_quiet = 0;
                if ($countones(seen) == 1) begin
                    m_valid = 1;
                    for (int i = 0; i < 4; i++) begin
                        if (seen[i]) begin
                            if (m_tally[i] == TMAX) m_ovf = 1;
                            else m_tally[i] = m_tally[i] + 1;
                        end
                    end
                end else begin
                    m_invalid = 1;
                end
            end
        end else begin
            if (seen == 0) m_quiet = m_quiet + 1;
            else m_quiet = 0;
            if (m_quiet == HOLD) m_armed = 1;
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_clear();
            else model_step(btn, mode);
        end
    end

    // -------------------------------------------------------------------------
    // Per-cycle compare and pulse counters
    // -------------------------------------------------------------------------
    int dut_valid_cnt   = 0;
    int dut_invalid_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("cyc_valid",   int'(valid_vote_casted), int'(m_valid));
                check("cyc_invalid", int'(invalid_vote),      int'(m_invalid));
                check("cyc_cand1",   int'(vote_cand1),        m_tally[0]);
                check("cyc_cand2",   int'(vote_cand2),        m_tally[1]);
                check("cyc_cand3",   int'(vote_cand3),        m_tally[2]);
                check("cyc_cand4",   int'(vote_cand4),        m_tally[3]);
                check("cyc_overflow", int'(overflow),         int'(m_ovf));
                if (valid_vote_casted) dut_valid_cnt++;
                if (invalid_vote)      dut_invalid_cnt++;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic drive(input logic [3:0] m, input int n);
        repeat (n) begin
            @(negedge clk);
            btn = m;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},    int'(valid_vote_casted), 0);
        check({tag, "_invalid"},  int'(invalid_vote),      0);
        check({tag, "_cand1"},    int'(vote_cand1),        0);
        check({tag, "_cand2"},    int'(vote_cand2),        0);
        check({tag, "_cand3"},    int'(vote_cand3),        0);
        check({tag, "_cand4"},    int'(vote_cand4),        0);
        check({tag, "_overflow"}, int'(overflow),          0);
    endtask

    task automatic check_tallies(input string tag, input int c1, input int c2,
                                 input int c3, input int c4);
        check({tag, "_cand1"}, int'(vote_cand1), c1);
        check({tag, "_cand2"}, int'(vote_cand2), c2);
        check({tag, "_cand3"}, int'(vote_cand3), c3);
        check({tag, "_cand4"}, int'(vote_cand4), c4);
    endtask

    // Reset changes are placed 2 time units after a falling edge so they
    // never coincide with the compare process.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst  = 1'b0;
        btn  = 4'b0000;
        mode = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    int v0;
    int i0;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("init");
        #1;
        rst = 1'b1;
        drive(4'b0000, 3);

        // 1: single press of cand2; pulse at the second edge after sampling.
        v0 = dut_valid_cnt;
        @(negedge clk);
        btn = 4'b0010;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t1_no_pulse_k1", int'(valid_vote_casted), 0);
        check("t1_cand2_k1",    int'(vote_cand2),        0);
        @(posedge clk);
        #1;
        check("t1_pulse_k2",    int'(valid_vote_casted), 1);
        check("t1_cand2_k2",    int'(vote_cand2),        1);
        @(posedge clk);
        #1;
        check("t1_pulse_k3",    int'(valid_vote_casted), 0);
        drive(4'b0000, 12);
        check_tallies("t1", 0, 1, 0, 0);
        check("t1_pulses", dut_valid_cnt - v0, 1);
        check("t1_model_cand2", m_tally[1], 1);
        $display("[TB] t1 single press cand2: cand2=%0d", vote_cand2);

        // 2: long hold, exactly HOLD released cycles, press again.
        v0 = dut_valid_cnt;
        drive(4'b0001, 50);
        drive(4'b0000, 10);
        drive(4'b0001, 3);
        drive(4'b0000, 12);
        check_tallies("t2", 2, 1, 0, 0);
        check("t2_pulses", dut_valid_cnt - v0, 2);
        $display("[TB] t2 hold+repress cand1: cand1=%0d", vote_cand1);

        // 2b: release shorter than HOLD keeps the lock; second press is lost.
        v0 = dut_valid_cnt;
        drive(4'b0100, 3);
        drive(4'b0000, 5);
        drive(4'b0100, 3);
        drive(4'b0000, 12);
        check_tallies("t2b", 2, 1, 1, 0);
        check("t2b_pulses", dut_valid_cnt - v0, 1);
        $display("[TB] t2b short release cand3: cand3=%0d", vote_cand3);

        // 3: two buttons together -> invalid only.
        v0 = dut_valid_cnt;
        i0 = dut_invalid_cnt;
        drive(4'b1100, 3);
        drive(4'b0000, 12);
        check_tallies("t3", 2, 1, 1, 0);
        check("t3_valid",   dut_valid_cnt - v0,   0);
        check("t3_invalid", dut_invalid_cnt - i0, 1);
        $display("[TB] t3 cand3+cand4 together: invalid pulses=%0d", dut_invalid_cnt - i0);

        // 5: display mode freezes tallies; back in voting mode a press counts.
        v0 = dut_valid_cnt;
        i0 = dut_invalid_cnt;
        @(negedge clk);
        mode = 1'b1;
        drive(4'b0001, 3);
        drive(4'b1010, 3);
        drive(4'b0000, 12);
        check_tallies("t5a", 2, 1, 1, 0);
        check("t5a_valid",   dut_valid_cnt - v0,   0);
        check("t5a_invalid", dut_invalid_cnt - i0, 0);
        @(negedge clk);
        mode = 1'b0;
        drive(4'b0001, 3);
        drive(4'b0000, 12);
        check_tallies("t5b", 3, 1, 1, 0);
        check("t5b_valid", dut_valid_cnt - v0, 1);
        $display("[TB] t5 mode freeze then vote: cand1=%0d", vote_cand1);

        // 4: saturate cand1, then one more vote.
        do_reset();
        drive(4'b0000, 2);
        for (int n = 0; n < TMAX; n++) begin
            drive(4'b0001, 2);
            drive(4'b0000, 11);
        end
        check_tallies("t4_full", TMAX, 0, 0, 0);
        check("t4_ovf_before", int'(overflow), 0);
        check("t4_model_cand1", m_tally[0], TMAX);
        v0 = dut_valid_cnt;
        drive(4'b0001, 2);
        drive(4'b0000, 11);
        check_tallies("t4_sat", TMAX, 0, 0, 0);
        check("t4_ovf_after", int'(overflow), 1);
        check("t4_pulse",     dut_valid_cnt - v0, 1);
        // overflow is sticky across further voting
        drive(4'b0010, 2);
        drive(4'b0000, 11);
        check("t4_ovf_sticky", int'(overflow), 1);
        check_tallies("t4_after", TMAX, 1, 0, 0);
        $display("[TB] t4 saturation: cand1=%0d overflow=%0d", vote_cand1, overflow);

        // 6: asynchronous reset mid-LOCK, between clock edges.
        drive(4'b1000, 3);
        @(posedge clk);
        #3;
        rst = 1'b0;
        btn = 4'b0000;
        #1;
        check_all_zero("t6_async");
        @(negedge clk);
        #2;
        rst = 1'b1;
        v0 = dut_valid_cnt;
        drive(4'b0000, 2);
        drive(4'b0010, 3);
        drive(4'b0000, 12);
        check_tallies("t6_after", 0, 1, 0, 0);
        check("t6_ovf",   int'(overflow), 0);
        check("t6_pulse", dut_valid_cnt - v0, 1);
        $display("[TB] t6 async reset then vote: cand2=%0d", vote_cand2);

        drive(4'b0000, 3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
